// File: rtl/move_gen_sched_pkg.sv
// Shared definitions for the move generation scheduler.
// Holds the scheduler state encoding, move/column word widths and board geometry.
package move_gen_sched_pkg;

  localparam int unsigned N_COLS    = 8;
  localparam int unsigned N_ROWS    = 8;
  localparam int unsigned SQ_W      = 4;
  localparam int unsigned COL_W     = N_ROWS * SQ_W;    // 32 bits per column
  localparam int unsigned MOVE_W    = 160;
  localparam int unsigned COL_IDX_W = 3;
  localparam int unsigned BOARD_W   = N_COLS * COL_W;   // 256
  localparam int unsigned COLQ_W    = N_COLS * MOVE_W;  // 1280

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GEN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/move_gen_sched_rr_arb8.sv
// Combinational 8-way round-robin arbiter.
// Ports: req    - per-column request
//        ptr    - column where the search starts
//        gnt_idx- first requesting column at or after ptr (wrapping)
//        gnt_any- at least one request present
module rr_arb8
  import move_gen_sched_pkg::*;
(
  input  logic [N_COLS-1:0]    req,
  input  logic [COL_IDX_W-1:0] ptr,
  output logic [COL_IDX_W-1:0] gnt_idx,
  output logic                 gnt_any
);

  logic [COL_IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = N_COLS - 1; i >= 0; i--) begin
      idx = ptr + COL_IDX_W'(i);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_gen_sched.sv
// Move generation scheduler: latches a board, clears the column units, then
// drains the column FIFOs round-robin into a single valid/ready move stream.
// Ports: clk/reset_n      - clock, async active-low reset
//        start/board_in   - run request and board to evaluate
//        col_state/col_reset - board and clear to the column units
//        col_done/col_empty/col_rden/col_q - column unit status and FIFO read
//        mv_data/mv_col/mv_valid/mv_ready - move output stream
//        busy/done/move_count/timeout_err - run status
module move_gen_sched
  import move_gen_sched_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [BOARD_W-1:0]   board_in,
  output logic [BOARD_W-1:0]   col_state,
  output logic                 col_reset,
  input  logic [N_COLS-1:0]    col_done,
  input  logic [N_COLS-1:0]    col_empty,
  output logic [N_COLS-1:0]    col_rden,
  input  logic [COLQ_W-1:0]    col_q,
  output logic [MOVE_W-1:0]    mv_data,
  output logic [COL_IDX_W-1:0] mv_col,
  output logic                 mv_valid,
  input  logic                 mv_ready,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           move_count,
  output logic                 timeout_err
);

  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                   state_q, state_d;
  logic [CLR_W-1:0]         clr_cnt_q;
  logic [TO_W-1:0]          gen_cnt_q;
  logic [COL_IDX_W-1:0]     ptr_q, rd_col_q, gnt_idx;
  logic                     gnt_any, inflight_q;
  logic                     rd_go, accept, start_ok, gen_timeout, gen_finish;
  logic [N_COLS-1:0][MOVE_W-1:0] col_q_arr;

  assign col_q_arr = col_q;
  assign accept    = mv_valid & mv_ready;
  // Read strobe must react to same-cycle mv_ready to sustain one word per two cycles.
  assign col_rden  = rd_go ? (N_COLS'(1) << gnt_idx) : '0;

  rr_arb8 u_arb (
    .req     (~col_empty),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and read issue.
  always_comb begin
    state_d     = state_q;
    rd_go       = 1'b0;
    start_ok    = 1'b0;
    gen_finish  = 1'b0;
    gen_timeout = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) state_d = ST_GEN;
      end
      ST_GEN: begin
        gen_finish  = (col_done == '1) && (col_empty == '1) && !inflight_q && !mv_valid;
        gen_timeout = !gen_finish && (gen_cnt_q == TO_W'(TIMEOUT - 1));
        if (gen_finish || gen_timeout) state_d = ST_DONE;
        else rd_go = !inflight_q && (!mv_valid || mv_ready) && gnt_any;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, counters and registered status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_state   <= '0;
      col_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      clr_cnt_q   <= '0;
      gen_cnt_q   <= '0;
      ptr_q       <= '0;
      rd_col_q    <= '0;
      inflight_q  <= 1'b0;
      mv_data     <= '0;
      mv_col      <= '0;
      mv_valid    <= 1'b0;
      move_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      col_reset <= (state_d == ST_IDLE) || (state_d == ST_CLEAR);
      busy      <= (state_d == ST_CLEAR) || (state_d == ST_GEN);
      done      <= (state_d == ST_DONE);

      if (start_ok) begin
        col_state   <= board_in;
        clr_cnt_q   <= '0;
        gen_cnt_q   <= '0;
        ptr_q       <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + CLR_W'(1);
        if (state_q == ST_GEN)   gen_cnt_q <= gen_cnt_q + TO_W'(1);
        if (gen_timeout)         timeout_err <= 1'b1;
      end

      if (rd_go) begin
        ptr_q    <= gnt_idx + COL_IDX_W'(1);
        rd_col_q <= gnt_idx;
      end
      inflight_q <= rd_go;

      // FIFO data is valid the cycle after the strobe; reads only issue when the register frees.
      if (inflight_q) begin
        mv_data  <= col_q_arr[rd_col_q];
        mv_col   <= rd_col_q;
        mv_valid <= 1'b1;
      end else if (accept) begin
        mv_valid <= 1'b0;
      end

      if (start_ok) move_count <= '0;
      else if (accept && (move_count != 8'hFF)) move_count <= move_count + 8'd1;
    end
  end

endmodule
